// File: rtl/adc_acq_scheduler.sv
// Acquisition sequencer: paces measure pulses to the ADC reader,
// buffers returned samples and streams them out on valid/ready.
module adc_acq_scheduler #(
   parameter int DATA_WIDTH     = 24,
   parameter int PERIOD_WIDTH   = 16,
   parameter int COUNT_WIDTH    = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    arm,
   input  logic                    abort,
   input  logic [PERIOD_WIDTH-1:0] cfg_period,
   input  logic [COUNT_WIDTH-1:0]  cfg_count,
   input  logic                    clr_status,
   output logic                    measure,
   input  logic                    sample_valid,
   input  logic [DATA_WIDTH-1:0]   sample_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_last,
   output logic                    busy,
   output logic                    done,
   output logic                    overflow,
   output logic                    timeout
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int SW = (PERIOD_WIDTH > TW) ? PERIOD_WIDTH : TW;

   typedef enum logic [1:0] {IDLE, TRIG, WAIT_DATA, HOLDOFF} state_t;

   state_t                  state, state_n;
   logic [PERIOD_WIDTH-1:0] period_q;
   logic [COUNT_WIDTH-1:0]  remain_q;
   logic                    cont_q;
   logic [SW-1:0]           since_q;
   logic [SW-1:0]           period_ext;
   logic [SW-1:0]           period_eff;
   logic                    hold_go;
   logic                    tmo_hit;
   logic                    final_smp;
   logic                    start;
   logic                    take;
   logic                    tmo_evt;
   logic                    done_q;
   logic                    ovf_q;
   logic                    tmo_q;

   logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]           wptr, rptr;
   logic [CW-1:0]           cnt;
   logic                    pop;
   logic                    accept;

   // since_q counts cycles since the last measure; it drives both the
   // holdoff pacing and the conversion timeout.
   assign period_ext = SW'(period_q);
   assign period_eff = (period_ext < SW'(3)) ? SW'(3) : period_ext;
   assign hold_go    = since_q >= (period_eff - SW'(1));
   assign tmo_hit    = since_q >= SW'(TIMEOUT_CYCLES - 1);
   assign final_smp  = !cont_q && (remain_q == COUNT_WIDTH'(1));
   assign start      = (state == IDLE) && arm && !abort;
   assign take       = (state == WAIT_DATA) && sample_valid && !abort;
   assign tmo_evt    = (state == WAIT_DATA) && !sample_valid
                       && !abort && tmo_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (start) state_n = TRIG;
         TRIG:      state_n = abort ? IDLE : WAIT_DATA;
         WAIT_DATA: begin
            if (abort)             state_n = IDLE;
            else if (sample_valid) state_n = final_smp ? IDLE : HOLDOFF;
            else if (tmo_hit)      state_n = IDLE;
         end
         HOLDOFF: begin
            if (abort)        state_n = IDLE;
            else if (hold_go) state_n = TRIG;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      measure  = (state == TRIG) && !abort;
      busy     = (state != IDLE);
      done     = done_q;
      overflow = ovf_q;
      timeout  = tmo_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_q <= '0;
         remain_q <= '0;
         cont_q   <= 1'b0;
         since_q  <= '0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         if (start) begin
            period_q <= cfg_period;
            remain_q <= cfg_count;
            cont_q   <= (cfg_count == '0);
         end else if (take && !cont_q) begin
            remain_q <= remain_q - COUNT_WIDTH'(1);
         end
         if (state == TRIG)     since_q <= SW'(1);
         else if (since_q != '1) since_q <= since_q + SW'(1);
         done_q <= take && final_smp;
         if (take && !accept) ovf_q <= 1'b1;
         else if (clr_status) ovf_q <= 1'b0;
         if (tmo_evt)         tmo_q <= 1'b1;
         else if (clr_status) tmo_q <= 1'b0;
      end
   end

   assign pop    = m_valid && m_ready;
   assign accept = take && ((cnt < CW'(FIFO_DEPTH)) || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (accept) begin
            mem[wptr] <= {final_smp, sample_data};
            wptr      <= wptr + AW'(1);
         end
         if (pop) rptr <= rptr + AW'(1);
         cnt <= cnt + CW'(accept) - CW'(pop);
      end
   end

   assign m_valid = (cnt != '0);
   assign m_data  = mem[rptr][DATA_WIDTH-1:0];
   assign m_last  = mem[rptr][DATA_WIDTH];

endmodule

// File: tb/tb_adc_acq_scheduler.sv
// Scoreboard bench for adc_acq_scheduler with a behavioural ADC
// reader that answers each measure after a programmable latency.
module tb_adc_acq_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] cfg_period = '0;
   logic [15:0] cfg_count = '0;
   logic        clr_status = 1'b0;
   logic        measure;
   logic        sample_valid = 1'b0;
   logic [23:0] sample_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [23:0] m_data;
   logic        m_last;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        timeout;

   adc_acq_scheduler #(
      .DATA_WIDTH(24), .PERIOD_WIDTH(16), .COUNT_WIDTH(16),
      .FIFO_DEPTH(8), .TIMEOUT_CYCLES(4096)
   ) dut (
      .clk(clk), .rst(rst), .arm(arm), .abort(abort),
      .cfg_period(cfg_period), .cfg_count(cfg_count),
      .clr_status(clr_status), .measure(measure),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .busy(busy), .done(done),
      .overflow(overflow), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // reader model
   int          rd_lat = 0;
   logic [23:0] rd_base = '0;
   int          rd_mark = 0;
   bit          rd_kill = 1'b0;
   int          rd_sent = 0;
   int          cd = 0;

   always begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (rd_kill) cd = 0;
      else if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            sample_valid = 1'b1;
            sample_data  = rd_base + 24'(rd_sent - rd_mark);
            rd_sent++;
         end
      end
      #1;
      if (measure && rd_lat > 0 && !rst) cd = rd_lat;
   end

   // monitor / scoreboard
   logic [24:0] sbq[$];
   int          meas_q[$];
   int          done_cnt = 0;

   always begin
      @(negedge clk);
      #2;
      if (measure) meas_q.push_back(cyc);
      if (done) done_cnt++;
      if (m_valid && m_ready) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_beat: got 0x%0h, want no beat",
                     {m_last, m_data});
         end else begin
            check("beat", 32'({m_last, m_data}), 32'(sbq.pop_front()));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_arm(input logic [15:0] p, input logic [15:0] c);
      @(negedge clk);
      cfg_period = p;
      cfg_count  = c;
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int max);
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         #3;
         if (!busy) break;
      end
      check({nm, "_idle"}, 32'(busy), 0);
   endtask

   task automatic wait_sent(input string nm, input int n, input int max);
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         #3;
         if (rd_sent - rd_mark == n) break;
      end
      check({nm, "_sent"}, 32'(rd_sent - rd_mark), 32'(n));
   endtask

   task automatic setup(input int lat, input logic [23:0] base);
      rd_lat  = lat;
      rd_base = base;
      rd_mark = rd_sent;
   endtask

   task automatic check_spacing(input string nm, input int m0,
                                input int n, input int sp);
      check({nm, "_meas_n"}, 32'(meas_q.size() - m0), 32'(n));
      for (int i = 1; i < n && m0 + i < meas_q.size(); i++)
         check({nm, "_spacing"}, 32'(meas_q[m0+i] - meas_q[m0+i-1]),
               32'(sp));
   endtask

   task automatic check_zero_outputs(input string nm);
      check({nm, "_m_valid"},  32'(m_valid),  0);
      check({nm, "_m_data"},   32'(m_data),   0);
      check({nm, "_m_last"},   32'(m_last),   0);
      check({nm, "_busy"},     32'(busy),     0);
      check({nm, "_measure"},  32'(measure),  0);
      check({nm, "_done"},     32'(done),     0);
      check({nm, "_overflow"}, 32'(overflow), 0);
      check({nm, "_timeout"},  32'(timeout),  0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m0;
      int d0;
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b0;
      step(2);

      // T1: 4-sample burst, period 10, L=3
      setup(3, 24'h000100);
      m_ready = 1'b1;
      sbq.push_back({1'b0, 24'h000100});
      sbq.push_back({1'b0, 24'h000101});
      sbq.push_back({1'b0, 24'h000102});
      sbq.push_back({1'b1, 24'h000103});
      m0 = meas_q.size();
      d0 = done_cnt;
      pulse_arm(16'd10, 16'd4);
      wait_idle("t1", 200);
      step(3);
      check_spacing("t1", m0, 4, 10);
      check("t1_done", 32'(done_cnt - d0), 1);
      check("t1_sb_drained", 32'(sbq.size()), 0);

      // T2: period 2 shorter than L+2 -> spacing L+2 = 8
      setup(6, 24'h000200);
      sbq.push_back({1'b0, 24'h000200});
      sbq.push_back({1'b0, 24'h000201});
      sbq.push_back({1'b1, 24'h000202});
      m0 = meas_q.size();
      d0 = done_cnt;
      pulse_arm(16'd2, 16'd3);
      wait_idle("t2", 200);
      step(3);
      check_spacing("t2", m0, 3, 8);
      check("t2_done", 32'(done_cnt - d0), 1);
      check("t2_sb_drained", 32'(sbq.size()), 0);

      // T3: overflow with consumer stalled
      setup(1, 24'h000300);
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         sbq.push_back({1'b0, 24'h000300 + 24'(i)});
      m0 = meas_q.size();
      d0 = done_cnt;
      pulse_arm(16'd4, 16'd12);
      wait_sent("t3_ninth", 9, 300);
      check("t3_ovf_before", 32'(overflow), 0);
      check("t3_full_valid", 32'(m_valid), 1);
      step(1);
      #3;
      check("t3_ovf_after", 32'(overflow), 1);
      wait_idle("t3", 300);
      step(2);
      check_spacing("t3", m0, 12, 4);
      check("t3_done", 32'(done_cnt - d0), 1);
      check("t3_head", 32'(m_data), 32'h000300);
      @(negedge clk);
      m_ready = 1'b1;
      step(12);
      #3;
      check("t3_sb_drained", 32'(sbq.size()), 0);
      check("t3_empty", 32'(m_valid), 0);
      @(negedge clk);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      #3;
      check("t3_ovf_clr", 32'(overflow), 0);

      // T4: reader never answers
      setup(0, 24'h000400);
      m0 = meas_q.size();
      d0 = done_cnt;
      pulse_arm(16'd3, 16'd1);
      wait_idle("t4", 5000);
      check("t4_meas_n", 32'(meas_q.size() - m0), 1);
      if (meas_q.size() > m0)
         check("t4_idle_at", 32'(cyc - meas_q[m0]), 4096);
      check("t4_timeout", 32'(timeout), 1);
      step(2);
      check("t4_no_done", 32'(done_cnt - d0), 0);
      @(negedge clk);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      #3;
      check("t4_tmo_clr", 32'(timeout), 0);

      // T5: continuous mode, abort in holdoff, then arm+abort together
      setup(2, 24'h000500);
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         sbq.push_back({1'b0, 24'h000500 + 24'(i)});
      m0 = meas_q.size();
      d0 = done_cnt;
      pulse_arm(16'd6, 16'd0);
      wait_sent("t5_five", 5, 300);
      @(negedge clk);
      abort = 1'b1;
      #3;
      check("t5_holdoff_busy", 32'(busy), 1);
      check("t5_holdoff_meas", 32'(measure), 0);
      @(negedge clk);
      abort = 1'b0;
      step(20);
      #3;
      check("t5_busy", 32'(busy), 0);
      check_spacing("t5", m0, 5, 6);
      @(negedge clk);
      cfg_period = 16'd5;
      cfg_count  = 16'd2;
      arm   = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      arm   = 1'b0;
      abort = 1'b0;
      step(5);
      #3;
      check("t5_arm_ignored", 32'(busy), 0);
      check("t5_meas_after", 32'(meas_q.size() - m0), 5);
      check("t5_no_done", 32'(done_cnt - d0), 0);
      check("t5_fifo_kept", 32'(m_valid), 1);
      @(negedge clk);
      m_ready = 1'b1;
      step(8);
      #3;
      check("t5_sb_drained", 32'(sbq.size()), 0);

      // T6: async reset in WAIT_DATA with 3 entries buffered
      setup(8, 24'h000600);
      m_ready = 1'b0;
      m0 = meas_q.size();
      pulse_arm(16'd3, 16'd5);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #3;
         if (meas_q.size() - m0 == 4) break;
      end
      check("t6_fourth_meas", 32'(meas_q.size() - m0), 4);
      step(2);
      #3;
      check("t6_pre_valid", 32'(m_valid), 1);
      check("t6_pre_busy", 32'(busy), 1);
      rst = 1'b1;
      rd_kill = 1'b1;
      #1;
      check_zero_outputs("t6_rst");
      @(negedge clk);
      rst = 1'b0;
      step(2);
      rd_kill = 1'b0;
      setup(2, 24'h000700);
      m_ready = 1'b1;
      sbq.push_back({1'b0, 24'h000700});
      sbq.push_back({1'b1, 24'h000701});
      m0 = meas_q.size();
      d0 = done_cnt;
      pulse_arm(16'd5, 16'd2);
      wait_idle("t6", 100);
      step(3);
      check_spacing("t6", m0, 2, 5);
      check("t6_done", 32'(done_cnt - d0), 1);
      check("t6_sb_drained", 32'(sbq.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
